// File: rtl/i2c_master_regs_fifo.sv
// CPU-side register bank for the byte-level I2C core.
// It holds the TX/RX FIFOs, command latching, masked interrupt status and FIFO flush.
module i2c_master_regs_fifo #(
  parameter int unsigned AWIDTH   = 3,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TX_THR   = 1,
  parameter int unsigned RX_THR   = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [DWIDTH-1:0] DataIn,
  output logic [DWIDTH-1:0] DataOut,
  input  logic              Wr,
  input  logic              Rd,
  output logic              Int,
  output logic              Start,
  output logic              Stop,
  output logic              Read,
  output logic              Write,
  output logic              Tx_ack,
  output logic [7:0]        Tx_data,
  input  logic [7:0]        Rx_data,
  input  logic              Rx_ack,
  output logic [DWIDTH-1:0] Prescale,
  output logic              I2C_en,
  input  logic              I2C_busy,
  input  logic              I2C_done,
  input  logic              I2C_al
);
  localparam int unsigned TPW = $clog2(TX_DEPTH);
  localparam int unsigned TLW = TPW + 1;
  localparam int unsigned RPW = $clog2(RX_DEPTH);
  localparam int unsigned RLW = RPW + 1;

  localparam logic [AWIDTH-1:0] AddrPrer = AWIDTH'(0);
  localparam logic [AWIDTH-1:0] AddrCtr  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] AddrTxr  = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] AddrRxr  = AWIDTH'(3);
  localparam logic [AWIDTH-1:0] AddrCr   = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] AddrSr   = AWIDTH'(5);
  localparam logic [AWIDTH-1:0] AddrIer  = AWIDTH'(6);
  localparam logic [AWIDTH-1:0] AddrIsr  = AWIDTH'(7);

  logic [DWIDTH-1:0] prer_q, ctr_q, data_out_q, rdata;
  logic [4:0]        cr_q, cr_d;          // {STA, STO, RD, WR, ACK}
  logic [5:0]        ier_q, isr;
  logic [3:0]        sticky_q, sticky_d;  // {CMDERR, RXOVF, AL, DONE}
  logic              al_q, al_d, rxack_q, int_q;
  logic [7:0]        sr;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TPW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TLW-1:0] tx_level_q;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RPW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RLW-1:0] rx_level_q;

  logic wr_prer, wr_ctr, wr_txr, wr_cr, wr_ier, wr_isr, rd_rxr;
  logic tx_full, tx_empty, rx_full, rx_empty, tip;
  logic tx_flush, rx_flush, tx_push, tx_pop, rx_push, rx_pop;
  logic cmd_evt, wr_ok, cmd_err, rx_ovf;

  always_comb begin
    wr_prer  = Wr && (Addr == AddrPrer);
    wr_ctr   = Wr && (Addr == AddrCtr);
    wr_txr   = Wr && (Addr == AddrTxr);
    wr_cr    = Wr && (Addr == AddrCr);
    wr_ier   = Wr && (Addr == AddrIer);
    wr_isr   = Wr && (Addr == AddrIsr);
    rd_rxr   = Rd && (Addr == AddrRxr);
    tx_full  = (tx_level_q == TLW'(TX_DEPTH));
    tx_empty = (tx_level_q == '0);
    rx_full  = (rx_level_q == RLW'(RX_DEPTH));
    rx_empty = (rx_level_q == '0);
    tip      = |cr_q[4:1];
    cmd_evt  = I2C_done || I2C_al;
    tx_flush = wr_cr && DataIn[2];
    rx_flush = wr_cr && DataIn[1];
    tx_push  = wr_txr && !tx_full && !tx_flush;
    tx_pop   = I2C_done && cr_q[1] && !tx_empty && !tx_flush;
    rx_push  = I2C_done && cr_q[2] && !rx_full && !rx_flush;
    rx_pop   = rd_rxr && !rx_empty && !rx_flush;
    rx_ovf   = I2C_done && cr_q[2] && rx_full && !rx_flush;
    // WR needs a byte to send: one already queued or pushed in this same cycle.
    wr_ok    = tx_push || (!tx_empty && !tx_flush);
    cmd_err  = (wr_txr && tx_full) || (wr_cr && !cmd_evt && DataIn[4] && !wr_ok);

    cr_d = cr_q;
    if (cmd_evt) begin
      cr_d = {4'b0000, cr_q[0]};
    end else if (wr_cr) begin
      cr_d = {DataIn[7:5], DataIn[4] & wr_ok, DataIn[3]};
    end

    sticky_d = sticky_q;
    if (wr_isr) sticky_d = sticky_q & ~{DataIn[5], DataIn[4], DataIn[1], DataIn[0]};
    sticky_d = sticky_d | {cmd_err, rx_ovf, I2C_al, I2C_done};
    al_d     = (al_q && !(wr_isr && DataIn[1])) || I2C_al;

    isr = {sticky_q[3], sticky_q[2], rx_level_q >= RLW'(RX_THR), tx_level_q <= TLW'(TX_THR),
           sticky_q[1], sticky_q[0]};
    sr  = {rxack_q, I2C_busy, al_q, tx_full, tx_empty, rx_empty, tip, |(isr & ier_q)};

    rdata = '0;
    case (Addr)
      AddrPrer: rdata = prer_q;
      AddrCtr:  rdata = ctr_q;
      AddrTxr:  rdata[TLW-1:0] = tx_level_q;
      AddrRxr:  rdata[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
      AddrCr:   rdata[7:0] = {cr_q, 3'b000};
      AddrSr:   rdata[7:0] = sr;
      AddrIer:  rdata[5:0] = ier_q;
      AddrIsr:  rdata[5:0] = isr;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prer_q     <= '0;
      ctr_q      <= '0;
      ier_q      <= '0;
      cr_q       <= '0;
      sticky_q   <= '0;
      al_q       <= 1'b0;
      rxack_q    <= 1'b0;
      int_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (wr_prer && !tip) prer_q <= DataIn;
      if (wr_ctr) ctr_q <= DataIn;
      if (wr_ier) ier_q <= DataIn[5:0];
      if (I2C_done) rxack_q <= Rx_ack;
      if (Rd) data_out_q <= rdata;
      cr_q     <= cr_d;
      sticky_q <= sticky_d;
      al_q     <= al_d;
      int_q    <= ctr_q[6] & |(isr & ier_q);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TPW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TPW'(1);
      tx_level_q <= tx_level_q + TLW'(tx_push) - TLW'(tx_pop);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RPW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RPW'(1);
      rx_level_q <= rx_level_q + RLW'(rx_push) - RLW'(rx_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= DataIn[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= Rx_data;
  end

  assign DataOut  = data_out_q;
  assign Int      = int_q;
  assign Start    = cr_q[4];
  assign Stop     = cr_q[3];
  assign Read     = cr_q[2];
  assign Write    = cr_q[1];
  assign Tx_ack   = cr_q[0];
  assign Tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_q];
  assign Prescale = prer_q;
  assign I2C_en   = ctr_q[7];

endmodule
